// File: rtl/countdown_seq_pkg.sv
// Shared types for the countdown sequencer: FSM state enum and its encodings.
package countdown_seq_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_COUNT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        COUNT = ST_COUNT_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Requester-side bus of the countdown sequencer; pause exists only with COUNTDOWN_SEQ_PAUSE_EN.
interface countdown_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 3
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_count;
    logic [N_REQ-1:0]       req_ready;
    logic                   abort;
`ifdef COUNTDOWN_SEQ_PAUSE_EN
    logic                   pause;
`endif
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [WIDTH-1:0]       count;
    logic [IW-1:0]          owner;

    modport slave (
`ifdef COUNTDOWN_SEQ_PAUSE_EN
        input  pause,
`endif
        input  req_valid, req_count, abort,
        output req_ready, done, busy, count, owner
    );

    modport master (
`ifdef COUNTDOWN_SEQ_PAUSE_EN
        output pause,
`endif
        output req_valid, req_count, abort,
        input  req_ready, done, busy, count, owner
    );

endinterface

// File: rtl/countdown_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from i_last+1, wrapping.
module rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_last,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_grant_idx,
    output logic             o_grant_vld
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        return IW'((int'(base) + off) % N_REQ);
    endfunction

    logic [IW-1:0] w_cand;

    // Walk from the lowest priority offset down, so the nearest valid requester wins last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = wrap_idx(i_last, k);
            if (i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
                o_grant_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// One shared down counter time-multiplexed across N_REQ requesters via round-robin grants.
// Optional COUNTDOWN_SEQ_PAUSE_EN adds a pause input that freezes the countdown.
module countdown_sequencer
    import countdown_seq_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  WIDTH = 3,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_sequencer_if.slave  bus
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_last,  w_last_nxt;

    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_gnt_vld;
    logic [WIDTH-1:0] w_load;
    logic             w_pause;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req       (bus.req_valid),
        .i_last      (r_last),
        .o_grant     (w_gnt),
        .o_grant_idx (w_gnt_idx),
        .o_grant_vld (w_gnt_vld)
    );

`ifdef COUNTDOWN_SEQ_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_load = bus.req_count[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_owner <= '0;
            r_last  <= IW'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        bus.req_ready = '0;
        bus.done      = '0;
        case (r_state)
            IDLE: begin
                if (!reset) bus.req_ready = w_gnt;
                if (w_gnt_vld) begin
                    w_state_nxt = COUNT;
                    w_count_nxt = w_load;
                    w_owner_nxt = w_gnt_idx;
                    w_last_nxt  = w_gnt_idx;
                end
            end
            COUNT: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (w_pause) begin
                    w_state_nxt = COUNT;
                end else if (r_count == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
            DONE: begin
                bus.done[r_owner] = 1'b1;
                w_state_nxt       = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.count = r_count;
    assign bus.owner = r_owner;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed table-driven bench for countdown_sequencer plus a hand-written async-reset sequence.
module tb_countdown_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    countdown_sequencer_if #(.N_REQ(4), .WIDTH(3)) bus ();

    countdown_sequencer #(.N_REQ(4), .WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [11:0] cnt;
        logic        abort;
        logic        pause;
        logic [3:0]  ready;
        logic [3:0]  done;
        logic        busy;
        logic [2:0]  count;
        logic [1:0]  owner;
    } vec_t;

    vec_t vecs[$];
    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] valid, input logic [11:0] cnt,
                       input logic abort, input logic pause, input logic [3:0] ready,
                       input logic [3:0] done, input logic busy, input logic [2:0] count,
                       input logic [1:0] owner);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cnt = cnt; v.abort = abort; v.pause = pause;
        v.ready = ready; v.done = done; v.busy = busy; v.count = count; v.owner = owner;
        vecs.push_back(v);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_count = '0;
        bus.abort     = 1'b0;
`ifdef COUNTDOWN_SEQ_PAUSE_EN
        bus.pause     = 1'b0;
`endif
        #1 reset = 1'b1;

        // Reset, then requester 0 with value 5
        add(1, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd0);
        add(0, 4'b0001, 12'h005, 0, 0, 4'b0001, 4'b0000, 0, 3'd0, 2'd0);
        for (int k = 5; k >= 0; k--)
            add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'(k), 2'd0);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0001, 1, 3'd0, 2'd0);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd0);

        // Requester 2 with value 0
        add(0, 4'b0100, 12'h000, 0, 0, 4'b0100, 4'b0000, 0, 3'd0, 2'd0);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd0, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0100, 1, 3'd0, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd2);

        // Reset (ready masked), then all four valid with value 1: grants 0,1,2,3,0
        add(1, 4'b1111, 12'h249, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd0);
        for (int g = 0; g < 5; g++) begin
            logic [1:0] gi, prev;
            gi   = 2'(g % 4);
            prev = (g == 0) ? 2'd0 : 2'((g - 1) % 4);
            add(0, 4'b1111, 12'h249, 0, 0, 4'b0001 << gi, 4'b0000, 0, 3'd0, prev);
            add(0, 4'b1111, 12'h249, 0, 0, 4'b0000, 4'b0000, 1, 3'd1, gi);
            add(0, 4'b1111, 12'h249, 0, 0, 4'b0000, 4'b0000, 1, 3'd0, gi);
            add(0, 4'b1111, 12'h249, 0, 0, 4'b0000, 4'b0001 << gi, 1, 3'd0, gi);
        end

        // Requester 1 with value 7, abort at count 4
        add(0, 4'b0010, 12'h038, 0, 0, 4'b0010, 4'b0000, 0, 3'd0, 2'd0);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd7, 2'd1);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd6, 2'd1);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd5, 2'd1);
        add(0, 4'b0000, 12'h000, 1, 0, 4'b0000, 4'b0000, 1, 3'd4, 2'd1);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd1);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd1);

`ifdef COUNTDOWN_SEQ_PAUSE_EN
        // Requester 2 with value 4, pause held three cycles at count 2
        add(0, 4'b0100, 12'h100, 0, 0, 4'b0100, 4'b0000, 0, 3'd0, 2'd1);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd4, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd3, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 1, 4'b0000, 4'b0000, 1, 3'd2, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 1, 4'b0000, 4'b0000, 1, 3'd2, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 1, 4'b0000, 4'b0000, 1, 3'd2, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd2, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd1, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 1, 3'd0, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0100, 1, 3'd0, 2'd2);
        add(0, 4'b0000, 12'h000, 0, 0, 4'b0000, 4'b0000, 0, 3'd0, 2'd2);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            bus.req_valid = vecs[i].valid;
            bus.req_count = vecs[i].cnt;
            bus.abort     = vecs[i].abort;
`ifdef COUNTDOWN_SEQ_PAUSE_EN
            bus.pause     = vecs[i].pause;
`endif
            #1;
            chk($sformatf("row%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            chk($sformatf("row%0d done",  i), 32'(bus.done),      32'(vecs[i].done));
            chk($sformatf("row%0d busy",  i), 32'(bus.busy),      32'(vecs[i].busy));
            chk($sformatf("row%0d count", i), 32'(bus.count),     32'(vecs[i].count));
            chk($sformatf("row%0d owner", i), 32'(bus.owner),     32'(vecs[i].owner));
        end

        // Async reset mid-countdown: requester 3 with value 6, reset at count 3
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_count = 12'hC00;
        #1 chk("rst_seq grant3", 32'(bus.req_ready), 32'b1000);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1 chk("rst_seq load6", 32'(bus.count), 32'd6);
        repeat (3) @(negedge clk);
        #1 chk("rst_seq count3", 32'(bus.count), 32'd3);
        bus.req_valid = 4'b1111;
        bus.req_count = 12'h249;
        #1 reset = 1'b1;
        #1;
        chk("rst_seq count0", 32'(bus.count), 32'd0);
        chk("rst_seq busy0",  32'(bus.busy),  32'd0);
        chk("rst_seq ready0", 32'(bus.req_ready), 32'd0);
        chk("rst_seq owner0", 32'(bus.owner), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_seq first0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        #1;
        chk("rst_seq owner_after", 32'(bus.owner), 32'd0);
        chk("rst_seq count_after", 32'(bus.count), 32'd1);
        chk("rst_seq done_none",   32'(bus.done),  32'd0);
        bus.req_valid = 4'b0000;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Shared-countdown scheduler for the counter library. Up to N_REQ requesters each submit a load value. A round-robin arbiter grants one requester at a time. The granted value is loaded into a single synchronous down counter, and a one-cycle `done` pulse returns to that requester when the count reaches zero. The block sequences and shares one 3-bit-class down counter instead of instantiating one counter per client.

## Interface
- `N_REQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 3: counter width in bits.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  N_REQ  bit i means requester i has a countdown pending.
- `req_count`  in  N_REQ*WIDTH  slice [i*WIDTH +: WIDTH] is requester i's load value.
- `req_ready`  out  N_REQ  one-hot, combinational; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `abort`  in  1  cancels the countdown in progress.
- `done`  out  N_REQ  one-hot, one-cycle pulse to the owner when its countdown completes.
- `busy`  out  1  high whenever the state is not IDLE.
- `count`  out  WIDTH  current counter value.
- `owner`  out  $clog2(N_REQ)  index of the current or most recent grantee.

## Operation
- States: IDLE, COUNT, DONE.
- **IDLE**
  - If any `req_valid` is set, the arbiter picks grant g.
  - g is the first valid index searching upward from `last_owner`+1, modulo N_REQ.
  - `req_ready[g]`=1 in the same cycle.
  - Next edge: `count` = `req_count` slice g, `owner`=g, `last_owner`=g, state → COUNT.
  - `req_ready` is 0 in every other state.
- **COUNT**
  - Priority order: `abort`, then pause (when configured), then count.
  - `abort`=1: state → IDLE, `count` → 0, no `done`.
  - Otherwise, if `count`==0: state → DONE.
  - Otherwise: `count` decrements by 1.
  - No wrap-around: the counter never decrements below 0.
- **DONE**
  - `done[owner]`=1 for exactly this cycle.
  - State → IDLE unconditionally.
  - `abort` is ignored here and in IDLE.
- Load value 0 is legal. The block spends one cycle in COUNT at 0, then goes to DONE.
- `req_count` is sampled only on the transfer cycle. `req_valid` may drop without a transfer; nothing is recorded.
- A requester may hold `req_valid` through its own countdown. It re-competes in IDLE, but round-robin gives the other valid requesters priority first.
- Reset values:
  - state IDLE, `count` 0, `owner` 0, `last_owner` N_REQ-1 (so requester 0 wins first).
  - `busy` 0, `done` 0.
  - `req_ready` forced to 0 while `reset` is high.
- Reset mid-countdown: all state clears immediately and no `done` is issued.

## Timing
- With the transfer at cycle T and load value V:
  - COUNT runs from T+1 (`count`=V) to T+1+V (`count`=0).
  - `done` pulses at T+2+V.
  - IDLE at T+3+V, where a new grant is possible in the same cycle.
- Minimum spacing between grants is V+3 cycles.
- `busy` rises at T+1 and falls at T+3+V.
- `req_ready` and the arbitration are combinational from registered state and `req_valid`. There is no path from `req_count` to any output.

## Configuration
- `COUNTDOWN_SEQ_PAUSE_EN` defined:
  - Adds input port `pause` (1 bit).
  - In COUNT with `abort`=0 and `pause`=1, `count` and state hold.
  - `abort` overrides `pause`.
- Undefined: no `pause` port; the countdown never stalls.

## Structure
- Package `countdown_seq_pkg` holds the `state_t` enum (IDLE, COUNT, DONE) and the state encoding constants.
- Sub-module `rr_arbiter`:
  - Parameter N_REQ.
  - Inputs: `req` vector, `last` pointer.
  - Output: one-hot `grant` and its index.
  - Purely combinational.
- Top-level `countdown_sequencer` holds the FSM, counter, owner and pointer registers.

## Test plan
- Reset, then `req_valid`=0001, slice0=5:
  - `req_ready[0]`=1 at T.
  - `count` = 5,4,3,2,1,0 over T+1..T+6.
  - `done[0]` at T+7; `busy` low at T+8.
- `req_valid`=0100, slice2=0: `done[2]` at T+2; `count` stays 0.
- All four valid continuously, each value 1:
  - Grant order 0,1,2,3,0.
  - Grants every 4 cycles; `done` one-hot each time.
- Value 7, `abort` pulsed when `count`=4:
  - Next cycle IDLE, `count`=0, `busy`=0.
  - No `done` pulse.
- Value 6, async `reset` while `count`=3:
  - Immediately `count`=0, `busy`=0.
  - After release with `req_valid`=1111, requester 0 is granted first.
- With `COUNTDOWN_SEQ_PAUSE_EN`: value 4, `pause` high 3 cycles at `count`=2 → `count` holds at 2 and `done` arrives at T+9 instead of T+6.
